alex_spi_ctrl: RTL

Sequencer that loads the Alex filter board over its three-wire serial interface. Packs the HPF/LPF codes, antenna, attenuator, preamp and PTT selections into a 16-bit TX word and a 16-bit RX word. Re-sends both words whenever any input changes or an update is forced. It sits between the band decoders (HPF/LPF select) and the Alex connector pins, and guarantees complete, glitch-free frames.

---
 rtl/alex_pkg.sv | 53 +++++
 rtl/alex_spi_shifter.sv | 72 +++++++
 rtl/alex_spi_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alex_pkg.sv
// Shared types and field layout for the Alex filter board loader.
// Word packing helpers keep the bit map in one place.
package alex_pkg;

    localparam int WORD_W = 16;
    localparam int BITS_PER_FRAME = 32;

    localparam int LPF_LSB = 9;
    localparam int ANT_LSB = 6;
    localparam int PTT_BIT = 5;
    localparam int HPF_LSB = 10;
    localparam int ATT_LSB = 8;
    localparam int RXA_LSB = 6;
    localparam int PRE_BIT = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SHIFT_TX,
        S_STROBE_TX,
        S_SHIFT_RX,
        S_STROBE_RX
    } state_t;

    function automatic logic [WORD_W-1:0] pack_tx(
        input logic [6:0] lpf,
        input logic [2:0] ant,
        input logic       ptt
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[LPF_LSB +: 7] = lpf;
        w[ANT_LSB +: 3] = ant;
        w[PTT_BIT] = ptt;
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] pack_rx(
        input logic [5:0] hpf,
        input logic [1:0] att,
        input logic [1:0] rxa,
        input logic       pre
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[HPF_LSB +: 6] = hpf;
        w[ATT_LSB +: 2] = att;
        w[RXA_LSB +: 2] = rxa;
        w[PRE_BIT] = pre;
        return w;
    endfunction

endpackage

// File: rtl/alex_spi_shifter.sv
// 16-bit MSB-first serialiser with CLK_DIV half-bit timing.
// Reloaded by the top for the TX word and then the RX word.
module alex_spi_shifter
    import alex_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    output logic              sdata,
    output logic              sclk,
    output logic              done
);

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
    localparam logic [3:0] LAST = 4'(WORD_W - 1);

    logic [WORD_W-1:0] sreg;
    logic [7:0]        cnt;
    logic [3:0]        bitn;
    logic              active;
    logic              half;
    logic              tick;

    assign tick = (cnt == DIV_M1);
    assign done = active & half & tick & (bitn == LAST);

    // half=0 is the low phase of a bit, half=1 the high phase
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sreg   <= '0;
            cnt    <= '0;
            bitn   <= '0;
            active <= 1'b0;
            half   <= 1'b0;
            sdata  <= 1'b0;
            sclk   <= 1'b0;
        end else if (load) begin
            sreg   <= data;
            sdata  <= data[WORD_W-1];
            sclk   <= 1'b0;
            active <= 1'b1;
            half   <= 1'b0;
            cnt    <= '0;
            bitn   <= '0;
        end else if (active) begin
            if (!tick) begin
                cnt <= cnt + 8'd1;
            end else begin
                cnt <= '0;
                if (!half) begin
                    half <= 1'b1;
                    sclk <= 1'b1;
                end else begin
                    half <= 1'b0;
                    sclk <= 1'b0;
                    sreg <= {sreg[WORD_W-2:0], 1'b0};
                    if (bitn == LAST) begin
                        active <= 1'b0;
                        sdata  <= 1'b0;
                    end else begin
                        bitn  <= bitn + 4'd1;
                        sdata <= sreg[WORD_W-2];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/alex_spi_ctrl.sv
// Alex board loader: change detection, frame sequencing and
// load strobes around a shared serialiser.
module alex_spi_ctrl
    import alex_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] hpf,
    input  logic [6:0] lpf,
    input  logic [2:0] ant_sel,
    input  logic       ptt,
    input  logic [1:0] atten,
    input  logic [1:0] rx_ant,
    input  logic       preamp,
    input  logic       force_update,
    output logic       SPI_data,
    output logic       SPI_clock,
    output logic       Tx_load_strobe,
    output logic       Rx_load_strobe,
    output logic       busy
);

    localparam logic [9:0] STB_LO  = 10'(CLK_DIV);
    localparam logic [9:0] STB_HI  = 10'(2 * CLK_DIV);
    localparam logic [9:0] STB_END = 10'(4 * CLK_DIV - 1);

    state_t                    state;
    logic [WORD_W-1:0]         tx_word;
    logic [WORD_W-1:0]         rx_word;
    logic [WORD_W-1:0]         rx_buf;
    logic [BITS_PER_FRAME-1:0] sent_word;
    logic                      first_send;
    logic                      pending_force;
    logic [9:0]                tmr;
    logic [9:0]                tmr_nx;
    logic                      start;
    logic                      stb_on;
    logic                      sh_load;
    logic                      sh_done;
    logic [WORD_W-1:0]         sh_data;

    assign tx_word = pack_tx(lpf, ant_sel, ptt);
    assign rx_word = pack_rx(hpf, atten, rx_ant, preamp);
    assign start   = ({tx_word, rx_word} != sent_word)
                   | pending_force | first_send;
    assign tmr_nx  = tmr + 10'd1;
    assign stb_on  = (tmr_nx >= STB_LO) && (tmr_nx < STB_HI);

    // TX word is loaded in LATCH, RX word on the last strobe-gap cycle
    assign sh_load = (state == S_LATCH)
                   | ((state == S_STROBE_TX) && (tmr == STB_END));
    assign sh_data = (state == S_LATCH) ? tx_word : rx_buf;

    alex_spi_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shift (
        .clock  (clock),
        .reset_n(reset_n),
        .load   (sh_load),
        .data   (sh_data),
        .sdata  (SPI_data),
        .sclk   (SPI_clock),
        .done   (sh_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            first_send     <= 1'b1;
            pending_force  <= 1'b0;
            sent_word      <= '0;
            rx_buf         <= '0;
            tmr            <= '0;
            busy           <= 1'b0;
            Tx_load_strobe <= 1'b0;
            Rx_load_strobe <= 1'b0;
        end else begin
            if (force_update) begin
                pending_force <= 1'b1;
            end else if (state == S_LATCH) begin
                pending_force <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LATCH;
                        busy  <= 1'b1;
                    end
                end
                S_LATCH: begin
                    sent_word  <= {tx_word, rx_word};
                    rx_buf     <= rx_word;
                    first_send <= 1'b0;
                    tmr        <= '0;
                    state      <= S_SHIFT_TX;
                end
                S_SHIFT_TX: begin
                    if (sh_done) state <= S_STROBE_TX;
                end
                S_STROBE_TX: begin
                    tmr            <= tmr_nx;
                    Tx_load_strobe <= stb_on;
                    if (tmr == STB_END) begin
                        tmr            <= '0;
                        Tx_load_strobe <= 1'b0;
                        state          <= S_SHIFT_RX;
                    end
                end
                S_SHIFT_RX: begin
                    if (sh_done) state <= S_STROBE_RX;
                end
                S_STROBE_RX: begin
                    tmr            <= tmr_nx;
                    Rx_load_strobe <= stb_on;
                    if (tmr == STB_END) begin
                        tmr            <= '0;
                        Rx_load_strobe <= 1'b0;
                        busy           <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
